// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32 subset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic [6:0]  opcode_i,
    input  logic        zero_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic [2:0]  imm_sel_o,
    output logic        alu_src_o,
    output logic [1:0]  alu_op_o,
    output logic        reg_we_o,
    output logic        wb_sel_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] instr_cnt_o
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    op_q;
    logic [WW-1:0] wait_cnt_q;
    logic [31:0]   instr_cnt_q;
    logic          waiting, timeout, retire;
    logic [2:0]    imm_kind;

    // A request may sit unanswered for at most MEM_TIMEOUT cycles; the last one trips ERR.
    assign waiting = (state_q == S_FETCH && !imem_ready_i) || (state_q == S_MEM && !dmem_ready_i);
    assign timeout = waiting && (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   if (run_i) state_d = S_FETCH;
            S_FETCH:  if (imem_ready_i) state_d = S_DECODE;
                      else if (timeout) state_d = S_ERR;
            S_DECODE: begin
                case (opcode_i)
                    OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                    default:                          state_d = S_ERR;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I:   state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ:       retire  = 1'b1;
                    default:      state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                if (dmem_ready_i) begin
                    if (op_q == OP_SW) retire  = 1'b1;
                    else               state_d = S_WB;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_WB:    retire = 1'b1;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
        if (retire) state_d = run_i ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q        <= 7'd0;
            wait_cnt_q  <= '0;
            instr_cnt_q <= 32'd0;
        end else begin
            if (state_q == S_DECODE) op_q <= opcode_i;
            if (state_d != state_q)  wait_cnt_q <= '0;
            else if (waiting)        wait_cnt_q <= wait_cnt_q + 1'b1;
            if (retire)              instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    always_comb begin
        case (op_q)
            OP_I, OP_LW: imm_kind = 3'd1;
            OP_SW:       imm_kind = 3'd2;
            OP_BEQ:      imm_kind = 3'd3;
            default:     imm_kind = 3'd0;
        endcase
    end

    always_comb begin
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_sel_o   = 1'b0;
        imm_sel_o  = 3'd0;
        alu_src_o  = 1'b0;
        alu_op_o   = 2'b00;
        reg_we_o   = 1'b0;
        wb_sel_o   = 1'b0;
        busy_o     = 1'b0;
        err_o      = 1'b0;
        case (state_q)
            S_FETCH: begin
                busy_o     = 1'b1;
                imem_req_o = 1'b1;
                ir_we_o    = imem_ready_i;
            end
            S_DECODE: busy_o = 1'b1;
            S_EXEC: begin
                busy_o    = 1'b1;
                imm_sel_o = imm_kind;
                case (op_q)
                    OP_R:         alu_op_o = 2'b10;
                    OP_I: begin
                        alu_src_o = 1'b1;
                        alu_op_o  = 2'b10;
                    end
                    OP_LW, OP_SW: alu_src_o = 1'b1;
                    OP_BEQ: begin
                        alu_op_o = 2'b01;
                        pc_we_o  = 1'b1;
                        pc_sel_o = zero_i;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                busy_o     = 1'b1;
                imm_sel_o  = imm_kind;
                dmem_req_o = 1'b1;
                dmem_we_o  = (op_q == OP_SW);
                pc_we_o    = dmem_ready_i && (op_q == OP_SW);
            end
            S_WB: begin
                busy_o    = 1'b1;
                imm_sel_o = imm_kind;
                reg_we_o  = 1'b1;
                wb_sel_o  = (op_q == OP_LW);
                pc_we_o   = 1'b1;
            end
            S_ERR:   err_o = 1'b1;
            default: ;
        endcase
    end

    assign instr_cnt_o = instr_cnt_q;
endmodule
